// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtractor.
package serial_subtractor_pkg;

  // Operation sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default geometry; instances override through module parameters.
  localparam int N_DEFAULT = 64;
  localparam int W_DEFAULT = 8;
  localparam int CHUNKS    = N_DEFAULT / W_DEFAULT;
  localparam int CNT_W     = (CHUNKS <= 1) ? 1 : $clog2(CHUNKS);

  // Number of W-bit chunks making up one N-bit operand.
  function automatic int chunk_count(input int n, input int w);
    return n / w;
  endfunction

  // Chunk counter width; never narrower than one bit so W==N still has a counter.
  function automatic int cnt_width(input int n, input int w);
    return ((n / w) <= 1) ? 1 : $clog2(n / w);
  endfunction

endpackage

// File: rtl/serial_subtractor_chunk_sub.sv
// One W-bit slice of the subtractor: {bo, d} = x - z - bi.
// Built as an adder (x + ~z + ~bi) so it maps onto ordinary carry chains;
// the borrow out is the inverted carry out.
module chunk_sub
  import serial_subtractor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] z,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);

  logic [W:0] sum;

  // Add the inverted subtrahend with the inverted borrow as carry-in.
  always_comb begin
    sum = {1'b0, x} + {1'b0, ~z} + {{W{1'b0}}, ~bi};
    d   = sum[W-1:0];
    bo  = ~sum[W];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor y = a - b - bin, W bits per cycle, LSB chunk first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high (unless rst)
// RUN   | one chunk per cycle through chunk_sub, borrow carried in brw_q
// DONE  | result held on y/bout/ovf with out_valid until out_ready
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         bout,
  output logic         ovf
);

  localparam int NCHUNK = chunk_count(N, W);
  localparam int CW     = cnt_width(N, W);

  // A non-integral chunk count would silently drop the top bits.
  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_geometry
    $fatal(1, "serial_subtractor: N must be a positive multiple of W");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            brw_q, brw_d;
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic [N-1:0]    y_q, y_d;
  logic            bout_q, bout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    chunk_d;
  logic            chunk_bo;
  logic [N-1:0]    y_shift;
  logic            last_chunk;

  // The operand registers shift right, so the active chunk is always the low W bits.
  chunk_sub #(.W(W)) u_chunk_sub (
    .x  (a_q[W-1:0]),
    .z  (b_q[W-1:0]),
    .bi (brw_q),
    .d  (chunk_d),
    .bo (chunk_bo)
  );

  // Results enter at the top and walk down; after NCHUNK shifts chunk 0 sits at bit 0.
  if (W == N) begin : g_single_chunk
    assign y_shift = chunk_d;
  end else begin : g_multi_chunk
    assign y_shift = {chunk_d, y_q[N-1:W]};
  end

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    y_d     = y_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> W;
        b_d   = b_q >> W;
        brw_d = chunk_bo;
        y_d   = y_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_chunk) begin
          // The final chunk carries the result sign bit in its top position.
          bout_d  = chunk_bo;
          ovf_d   = (a_msb_q != b_msb_q) && (chunk_d[W-1] != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      y_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      y_q     <= y_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags come only from registered state (and rst), never from the inputs.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    y         = y_q;
    bout      = bout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=64/W=8, N=16/W=4 and N=W=8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // N=64, W=8 instance
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [63:0] a, b, y;

  // N=16, W=4 instance
  logic        s_in_valid, s_in_ready, s_bin, s_out_valid, s_out_ready, s_bout, s_ovf;
  logic [15:0] s_a, s_b, s_y;

  // N=W=8 instance
  logic        t_in_valid, t_in_ready, t_bin, t_out_valid, t_out_ready, t_bout, t_ovf;
  logic [7:0]  t_a, t_b, t_y;

  int vectors = 0;
  int errs    = 0;

  serial_subtractor #(.N(64), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.N(16), .W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .y(s_y), .bout(s_bout), .ovf(s_ovf)
  );

  serial_subtractor #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a(t_a), .b(t_b), .bin(t_bin), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .y(t_y), .bout(t_bout), .ovf(t_ovf)
  );

  // Hand one operand set to the 64-bit instance and count edges until out_valid.
  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ibin,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
    t_in_valid = 1'b0; t_out_ready = 1'b0; t_a = '0; t_b = '0; t_bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    vectors++; if (y !== 64'd0) begin errs++; $display("FAIL rst_y: got %h required 0", y); end
    vectors++; if (bout !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL rst_flags: bout=%b ovf=%b required 0 0", bout, ovf); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_in_ready: got %b required 1", in_ready); end
  endtask

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic        vbin;
    logic [63:0] vy;
    logic        vbout;
    logic        vovf;
  } vec_t;

  task automatic test_vectors();
    vec_t tbl[6];
    int lat;
    tbl[0] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[1] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tbl[2] = '{64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0};
    tbl[3] = '{64'd3, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].va, tbl[i].vb, tbl[i].vbin, lat);
      vectors++; if (lat !== 8) begin errs++; $display("FAIL vec%0d_latency: got %0d required 8", i, lat); end
      vectors++; if (y !== tbl[i].vy) begin errs++; $display("FAIL vec%0d_y: got %h required %h", i, y, tbl[i].vy); end
      vectors++; if (bout !== tbl[i].vbout) begin errs++; $display("FAIL vec%0d_bout: got %b required %b", i, bout, tbl[i].vbout); end
      vectors++; if (ovf !== tbl[i].vovf) begin errs++; $display("FAIL vec%0d_ovf: got %b required %b", i, ovf, tbl[i].vovf); end
      complete();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(64'd100, 64'd58, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || y !== 64'd42 || bout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold%0d: out_valid=%b y=%h bout=%b ovf=%b in_ready=%b required 1 2a 0 0 0",
                 c, out_valid, y, bout, ovf, in_ready);
      end
    end
    complete();
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_release_out_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(64'h0000_0001_0000_0000, 64'd1, 1'b0, lat);
    vectors++; if (y !== 64'h0000_0000_FFFF_FFFF || lat !== 8) begin errs++; $display("FAIL b2b_first: y=%h lat=%0d required ffffffff 8", y, lat); end
    complete();
    issue(64'd20, 64'd7, 1'b1, lat);
    vectors++; if (y !== 64'd12 || lat !== 8) begin errs++; $display("FAIL b2b_second: y=%h lat=%0d required c 8", y, lat); end
    complete();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_1234; b = 64'd99; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    vectors++; if (y !== 64'd0) begin errs++; $display("FAIL midrst_y: got %h required 0", y); end
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_idle: in_ready=%b required 1", in_ready); end
    issue(64'd10, 64'd4, 1'b0, lat);
    vectors++; if (y !== 64'd6 || bout !== 1'b0 || lat !== 8) begin errs++; $display("FAIL midrst_fresh: y=%h bout=%b lat=%0d required 6 0 8", y, bout, lat); end
    complete();
  endtask

  task automatic test_random_n64(input int nops);
    logic [63:0] ea, eb, ey;
    logic        ebin, eovf;
    logic [64:0] full;
    int          lat;
    for (int i = 0; i < nops; i++) begin
      ea = {$urandom, $urandom}; eb = {$urandom, $urandom}; ebin = 1'($urandom_range(0, 1));
      if (i % 10 == 0) eb = ea;
      full = {1'b0, ea} - {1'b0, eb} - {64'd0, ebin};
      ey   = full[63:0];
      eovf = (ea[63] != eb[63]) && (ey[63] != ea[63]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(ea, eb, ebin, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      vectors++;
      if (lat !== 8 || out_valid !== 1'b1 || y !== ey || bout !== full[64] || ovf !== eovf) begin
        errs++;
        $display("FAIL rnd64_%0d: lat=%0d v=%b y=%h bout=%b ovf=%b required 8 1 %h %b %b",
                 i, lat, out_valid, y, bout, ovf, ey, full[64], eovf);
      end
      complete();
    end
  endtask

  task automatic test_random_n16(input int nops);
    logic [15:0] ea, eb, ey;
    logic        ebin, eovf;
    logic [16:0] full;
    int          lat, g;
    for (int i = 0; i < nops; i++) begin
      ea = 16'($urandom); eb = 16'($urandom); ebin = 1'($urandom_range(0, 1));
      full = {1'b0, ea} - {1'b0, eb} - {16'd0, ebin};
      ey   = full[15:0];
      eovf = (ea[15] != eb[15]) && (ey[15] != ea[15]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      g = 0;
      while (!s_in_ready && g < 50) begin @(negedge clk); g++; end
      s_a = ea; s_b = eb; s_bin = ebin; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom);
      lat = 0;
      while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      vectors++;
      if (lat !== 4 || s_out_valid !== 1'b1 || s_y !== ey || s_bout !== full[16] || s_ovf !== eovf) begin
        errs++;
        $display("FAIL rnd16_%0d: lat=%0d v=%b y=%h bout=%b ovf=%b required 4 1 %h %b %b",
                 i, lat, s_out_valid, s_y, s_bout, s_ovf, ey, full[16], eovf);
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
  endtask

  task automatic test_random_n8(input int nops);
    logic [7:0] ea, eb, ey;
    logic       ebin, eovf;
    logic [8:0] full;
    int         lat, g;
    for (int i = 0; i < nops; i++) begin
      ea = 8'($urandom); eb = 8'($urandom); ebin = 1'($urandom_range(0, 1));
      full = {1'b0, ea} - {1'b0, eb} - {8'd0, ebin};
      ey   = full[7:0];
      eovf = (ea[7] != eb[7]) && (ey[7] != ea[7]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      g = 0;
      while (!t_in_ready && g < 50) begin @(negedge clk); g++; end
      t_a = ea; t_b = eb; t_bin = ebin; t_in_valid = 1'b1;
      @(posedge clk); #1;
      t_in_valid = 1'b0; t_a = 8'($urandom); t_b = 8'($urandom);
      lat = 0;
      while (!t_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      vectors++;
      if (lat !== 1 || t_out_valid !== 1'b1 || t_y !== ey || t_bout !== full[8] || t_ovf !== eovf) begin
        errs++;
        $display("FAIL rnd8_%0d: lat=%0d v=%b y=%h bout=%b ovf=%b required 1 1 %h %b %b",
                 i, lat, t_out_valid, t_y, t_bout, t_ovf, ey, full[8], eovf);
      end
      t_out_ready = 1'b1;
      @(posedge clk); #1;
      t_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random_n64(1000);
    test_random_n16(300);
    test_random_n8(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
